// File: rtl/dump_arbiter.sv
// Round-robin arbiter granting the shared accumulator readout port to one channel at a time.
// Define DUMP_ARBITER_EDGE_DETECT_EN to treat dump_req as a level (rising edge = request).
module dump_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_BITS    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CHANNELS-1:0] dump_req,
  input  logic                    grant_ack,
  input  logic [NUM_CHANNELS-1:0] overrun_clr,
  output logic                    grant_valid,
  output logic [CHAN_BITS-1:0]    grant_chan,
  output logic [NUM_CHANNELS-1:0] pending,
  output logic [NUM_CHANNELS-1:0] overrun
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [CHAN_BITS-1:0]    ptr;
  logic [NUM_CHANNELS-1:0] ev;
  logic [NUM_CHANNELS-1:0] grant_clr;
  logic [NUM_CHANNELS-1:0] ovr_set;
  logic [CHAN_BITS-1:0]    sel;
  logic                    sel_found;

  function automatic logic [CHAN_BITS-1:0] wrap_inc(input logic [CHAN_BITS-1:0] c);
    int n;
    n = (int'(c) + 1) % NUM_CHANNELS;
    return CHAN_BITS'(n);
  endfunction

`ifdef DUMP_ARBITER_EDGE_DETECT_EN
  logic [NUM_CHANNELS-1:0] prev;

  always_ff @(posedge clk) begin
    if (!reset_n) prev <= '0;
    else          prev <= dump_req;
  end

  assign ev = dump_req & ~prev;
`else
  assign ev = dump_req;
`endif

  // First pending channel at or after ptr, wrapping modulo NUM_CHANNELS.
  always_comb begin : sel_search
    int idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(ptr) + k) % NUM_CHANNELS;
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel       = CHAN_BITS'(idx);
      end
    end
  end

  always_comb begin
    grant_clr = '0;
    if (state == IDLE && sel_found) grant_clr[sel] = 1'b1;
  end

  // A request coinciding with its own grant-clear re-pends instead of overrunning.
  assign ovr_set = ev & pending & ~grant_clr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_chan  <= '0;
      ptr         <= '0;
      pending     <= '0;
      overrun     <= '0;
    end else begin
      pending <= (pending & ~grant_clr) | ev;
      overrun <= (overrun & ~overrun_clr) | ovr_set;
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_chan  <= sel;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ack) begin
            ptr         <= wrap_inc(grant_chan);
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
